// File: rtl/mul_issue_rsp_buf_if.sv
// Request, multiplier and response signals of the multiply
// issue/response buffer, grouped with a view for each side.
interface mul_issue_rsp_buf_if #(
   parameter int TAG_W = 4
);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [31:0]      req_x;
   logic [31:0]      req_y;
   logic [TAG_W-1:0] req_tag;
   logic             mul_in_valid;
   logic             mul_in_ready;
   logic [32:0]      mul_src2;
   logic [32:0]      mul_src1;
   logic             mul_out_valid;
   logic [63:0]      mul_result;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_data;
   logic [TAG_W-1:0] rsp_tag;
   logic             err;

   modport slave (
      input  req_valid, req_op, req_x, req_y, req_tag,
      output req_ready,
      output mul_in_valid, mul_src2, mul_src1,
      input  mul_in_ready, mul_out_valid, mul_result,
      output rsp_valid, rsp_data, rsp_tag, err,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_op, req_x, req_y, req_tag,
      input  req_ready,
      input  mul_in_valid, mul_src2, mul_src1,
      output mul_in_ready, mul_out_valid, mul_result,
      input  rsp_valid, rsp_data, rsp_tag, err,
      output rsp_ready
   );
endinterface

// File: rtl/mul_issue_rsp_buf.sv
// Operand extension and credit-gated issue into the booth multiplier,
// plus in-order buffering of its products into tagged responses.
module mul_issue_rsp_buf #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input logic                mul_clk,
   input logic                resetn,
   mul_issue_rsp_buf_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [CW-1:0]    outstanding;
   logic [CW-1:0]    dcount;
   logic [CW-1:0]    dcount_nxt;
   logic [AW-1:0]    mwp;
   logic [AW-1:0]    dwp;
   logic [AW-1:0]    rp;
   logic [1:0]       meta_op  [DEPTH];
   logic [TAG_W-1:0] meta_tag [DEPTH];
   logic [63:0]      data_mem [DEPTH];
   logic [63:0]      head;
   logic             rsp_vld_q;
   logic             err_q;
   logic             credit_ok;
   logic             issue;
   logic             pop;
   logic             owed;
   logic             push;
   logic             sx;
   logic             sy;

   // Sign-extension selects for x and y from the request opcode.
   always_comb begin
      sx = 1'b0;
      sy = 1'b0;
      unique case (bus.req_op)
         2'b01:   begin sx = 1'b1; sy = 1'b1; end
         2'b10:   sx = 1'b1;
         default: ;
      endcase
   end

   assign bus.mul_src2 = {sx & bus.req_x[31], bus.req_x};
   assign bus.mul_src1 = {sy & bus.req_y[31], bus.req_y};

   // Credit comes from the registered count only; a pop this cycle
   // frees its slot for the next cycle.
   assign credit_ok        = resetn && (outstanding < FULL);
   assign bus.mul_in_valid = bus.req_valid & credit_ok;
   assign bus.req_ready    = bus.mul_in_ready & credit_ok;
   assign issue            = bus.req_valid & bus.req_ready;

   assign bus.rsp_valid = rsp_vld_q;
   assign pop           = rsp_vld_q & bus.rsp_ready;

   // A product is owed only while some issued op has no data yet.
   assign owed = (dcount != outstanding);
   assign push = bus.mul_out_valid & owed;

   assign head         = data_mem[rp];
   assign bus.rsp_data = (meta_op[rp] == 2'b00) ? head[31:0] : head[63:32];
   assign bus.rsp_tag  = meta_tag[rp];
   assign bus.err      = err_q;

   // Next data occupancy from the product push and response pop.
   always_comb begin
      dcount_nxt = dcount;
      if (push && !pop) dcount_nxt = dcount + CW'(1);
      else if (pop && !push) dcount_nxt = dcount - CW'(1);
   end

   // Credit counter: issued requests whose response is not yet taken.
   always_ff @(posedge mul_clk) begin
      if (!resetn) outstanding <= '0;
      else if (issue && !pop) outstanding <= outstanding + CW'(1);
      else if (pop && !issue) outstanding <= outstanding - CW'(1);
   end

   // Meta entries {op, tag} captured at issue.
   always_ff @(posedge mul_clk) begin
      if (issue) begin
         meta_op[mwp]  <= bus.req_op;
         meta_tag[mwp] <= bus.req_tag;
      end
   end

   // Product storage; unowed products are never written.
   always_ff @(posedge mul_clk) begin
      if (push) data_mem[dwp] <= bus.mul_result;
   end

   // Pointers, occupancy, registered response valid and sticky error.
   always_ff @(posedge mul_clk) begin
      if (!resetn) begin
         mwp       <= '0;
         dwp       <= '0;
         rp        <= '0;
         dcount    <= '0;
         rsp_vld_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (issue) mwp <= mwp + AW'(1);
         if (push) dwp <= dwp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         dcount    <= dcount_nxt;
         rsp_vld_q <= (dcount_nxt != '0);
         if (bus.mul_out_valid && !owed) err_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mul_issue_rsp_buf.sv
// Bench for mul_issue_rsp_buf: behavioural 2-cycle multiplier,
// response scoreboard, vector table and directed corner sequences.
module tb_mul_issue_rsp_buf;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic mul_clk = 1'b0;
   logic resetn  = 1'b0;

   always #5 mul_clk = ~mul_clk;

   mul_issue_rsp_buf_if #(.TAG_W(TAG_W)) bus ();

   mul_issue_rsp_buf #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .mul_clk(mul_clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int n_iss = 0;
   int n_prod = 0;
   int n_pop = 0;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic [1:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      logic [32:0] s2;
      logic [32:0] s1;
      logic [31:0] d;
   } vec_t;
   vec_t tbl[7];

   logic        pv0 = 1'b0;
   logic        pv1 = 1'b0;
   logic [63:0] pr0 = '0;
   logic [63:0] pr1 = '0;
   logic        inj = 1'b0;
   logic [63:0] inj_data = '0;

   assign bus.mul_out_valid = pv1 | inj;
   assign bus.mul_result    = inj ? inj_data : pr1;

   function automatic void chk(input string nm, input logic [63:0] act,
                               input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void chkb(input string nm, input logic act,
                                input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [63:0] mul33(input logic [32:0] a,
                                         input logic [32:0] b);
      logic [65:0] ea, eb, p;
      ea = {{33{a[32]}}, a};
      eb = {{33{b[32]}}, b};
      p  = ea * eb;
      return p[63:0];
   endfunction

   function automatic logic [31:0] ref_rsp(input logic [1:0] op,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
      logic [63:0] ex, ey, p;
      ex = (op == 2'b01 || op == 2'b10) ? {{32{x[31]}}, x} : {32'd0, x};
      ey = (op == 2'b01) ? {{32{y[31]}}, y} : {32'd0, y};
      p  = ex * ey;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 7))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h8000_0000;
         2:       return 32'h0000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Multiplier model: fixed 2-cycle latency, in order, shares resetn.
   always @(posedge mul_clk) begin
      if (!resetn) begin
         pv0 <= 1'b0;
         pv1 <= 1'b0;
      end else begin
         pv1 <= pv0;
         pr1 <= pr0;
         pv0 <= bus.mul_in_valid & bus.mul_in_ready;
         pr0 <= mul33(bus.mul_src2, bus.mul_src1);
      end
   end

   // Monitor: push expectations at issue, compare at response pop.
   always @(negedge mul_clk) begin
      exp_t e;
      if (resetn) begin
         chkb("no_x",
              $isunknown({bus.rsp_valid, bus.req_ready,
                          bus.mul_in_valid, bus.err}), 1'b0);
         if (bus.req_valid && bus.req_ready) begin
            sbq.push_back({bus.req_tag,
                           ref_rsp(bus.req_op, bus.req_x, bus.req_y)});
            n_iss++;
         end
         if (pv1) n_prod++;
         if (bus.rsp_valid && bus.rsp_ready) begin
            n_pop++;
            if (sbq.size() == 0) begin
               chkb("sb_unexpected_rsp", 1'b1, 1'b0);
            end else begin
               e = sbq.pop_front();
               chk("sb_data", 64'(bus.rsp_data), 64'(e.data));
               chk("sb_tag", 64'(bus.rsp_tag), 64'(e.tag));
            end
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [31:0] x,
                        input logic [31:0] y,
                        input logic [TAG_W-1:0] tag, output bit ok);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_x     = x;
      bus.req_y     = y;
      bus.req_tag   = tag;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge mul_clk);
         if (bus.req_ready) ok = 1'b1;
      end
      @(posedge mul_clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      bit done;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge mul_clk);
         if (sbq.size() == 0 && !bus.rsp_valid && !pv0 && !pv1) done = 1'b1;
      end
      chk("drain_left", 64'(sbq.size()), 64'd0);
      @(posedge mul_clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(posedge mul_clk);
      #1;
      resetn = 1'b0;
      @(posedge mul_clk);
      #1;
      resetn = 1'b1;
      sbq.delete();
      n_prod = 0;
      n_pop  = 0;
   endtask

   initial begin
      bit ok;
      bit got;
      int cnt;
      int base;

      tbl[0] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 33'h0_FFFFFFFF, 33'h0_FFFFFFFF, 32'hFFFFFFFE};
      tbl[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 33'h1_FFFFFFFF, 33'h1_FFFFFFFF, 32'h00000000};
      tbl[2] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 33'h0_FFFFFFFF, 33'h0_FFFFFFFF, 32'h00000001};
      tbl[3] = '{2'b10, 32'hFFFFFFFF, 32'h00000002,
                 33'h1_FFFFFFFF, 33'h0_00000002, 32'hFFFFFFFF};
      tbl[4] = '{2'b01, 32'h80000000, 32'h80000000,
                 33'h1_80000000, 33'h1_80000000, 32'h40000000};
      tbl[5] = '{2'b10, 32'h7FFFFFFF, 32'hFFFFFFFF,
                 33'h0_7FFFFFFF, 33'h0_FFFFFFFF, 32'h7FFFFFFE};
      tbl[6] = '{2'b00, 32'h12345678, 32'h00000010,
                 33'h0_12345678, 33'h0_00000010, 32'h23456780};

      bus.req_valid    = 1'b0;
      bus.req_op       = 2'b00;
      bus.req_x        = '0;
      bus.req_y        = '0;
      bus.req_tag      = '0;
      bus.mul_in_ready = 1'b1;
      bus.rsp_ready    = 1'b0;

      // Reset state, including gating while resetn is low.
      repeat (2) @(posedge mul_clk);
      #1;
      bus.req_valid = 1'b1;
      @(negedge mul_clk);
      chkb("rst_req_ready", bus.req_ready, 1'b0);
      chkb("rst_mul_in_valid", bus.mul_in_valid, 1'b0);
      chkb("rst_rsp_valid", bus.rsp_valid, 1'b0);
      @(posedge mul_clk);
      #1;
      resetn = 1'b1;
      bus.req_valid = 1'b0;
      @(negedge mul_clk);
      chkb("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
      chkb("post_rst_err", bus.err, 1'b0);
      chkb("post_rst_req_ready", bus.req_ready, 1'b1);
      chkb("post_rst_in_valid", bus.mul_in_valid, 1'b0);
      @(posedge mul_clk);
      #1;

      // Vector table: operand extension and selected word.
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         bus.req_op  = tbl[i].op;
         bus.req_x   = tbl[i].x;
         bus.req_y   = tbl[i].y;
         #1;
         chk("tbl_src2", 64'(bus.mul_src2), 64'(tbl[i].s2));
         chk("tbl_src1", 64'(bus.mul_src1), 64'(tbl[i].s1));
         issue(tbl[i].op, tbl[i].x, tbl[i].y, TAG_W'(i), ok);
         chkb("tbl_accept", ok, 1'b1);
         got = 1'b0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(negedge mul_clk);
            if (bus.rsp_valid) got = 1'b1;
         end
         chkb("tbl_rsp_seen", got, 1'b1);
         if (got) begin
            chk("tbl_rsp_data", 64'(bus.rsp_data), 64'(tbl[i].d));
            chk("tbl_rsp_tag", 64'(bus.rsp_tag), 64'(i));
         end
         @(posedge mul_clk);
         #1;
      end

      // Credit stall: four outstanding block the fifth.
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         issue(2'b00, 32'(i + 1), 32'd3, TAG_W'(i), ok);
         chkb("stall_accept", ok, 1'b1);
      end
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b00;
      bus.req_x     = 32'd5;
      bus.req_y     = 32'd3;
      bus.req_tag   = TAG_W'(4);
      for (int c = 0; c < 4; c++) begin
         @(negedge mul_clk);
         chkb("stall_req_ready", bus.req_ready, 1'b0);
         chkb("stall_in_valid", bus.mul_in_valid, 1'b0);
      end
      chkb("stall_rsp_valid", bus.rsp_valid, 1'b1);
      @(posedge mul_clk);
      #1;
      bus.rsp_ready = 1'b1;
      @(negedge mul_clk);
      chkb("credit_no_bypass", bus.req_ready, 1'b0);
      @(negedge mul_clk);
      chkb("credit_after_pop", bus.req_ready, 1'b1);
      chkb("stall_pop2_valid", bus.rsp_valid, 1'b1);
      @(posedge mul_clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge mul_clk);
      chkb("stall_pop3_valid", bus.rsp_valid, 1'b1);
      @(posedge mul_clk);
      #1;
      drain();

      // Product push and response pop on the same edge, two buffered.
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         issue(2'b11, rnd_word(), rnd_word(), TAG_W'(8 + i), ok);
         chkb("pp_accept", ok, 1'b1);
      end
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         if (bus.mul_out_valid && (n_prod - n_pop) == 2) got = 1'b1;
         else begin
            @(posedge mul_clk);
            #1;
         end
      end
      chkb("pp_sync", got, 1'b1);
      bus.rsp_ready = 1'b1;
      @(negedge mul_clk);
      chkb("pp_pop_valid", bus.rsp_valid, 1'b1);
      @(posedge mul_clk);
      #1;
      bus.rsp_ready = 1'b0;
      @(posedge mul_clk);
      #1;
      bus.rsp_ready = 1'b1;
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge mul_clk);
         if (bus.rsp_valid) cnt++;
      end
      chk("pp_count", 64'(cnt), 64'd2);
      @(posedge mul_clk);
      #1;
      drain();

      // Random run against the reference product.
      base = n_iss;
      for (int c = 0; c < 60000 && (n_iss - base) < 10000; c++) begin
         @(posedge mul_clk);
         #1;
         bus.req_valid    = ($urandom_range(0, 3) != 0);
         bus.req_op       = 2'($urandom_range(0, 3));
         bus.req_x        = rnd_word();
         bus.req_y        = rnd_word();
         bus.req_tag      = TAG_W'($urandom);
         bus.mul_in_ready = ($urandom_range(0, 3) != 0);
         bus.rsp_ready    = ($urandom_range(0, 3) != 0);
      end
      chkb("rand_ops_done", (n_iss - base) >= 10000, 1'b1);
      bus.mul_in_ready = 1'b1;
      drain();
      chkb("rand_err", bus.err, 1'b0);

      // Reset with three outstanding, then a late product.
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         issue(2'b00, 32'(i + 7), 32'd9, TAG_W'(i + 1), ok);
         chkb("rst3_accept", ok, 1'b1);
      end
      pulse_reset();
      @(negedge mul_clk);
      chkb("rst3_rsp_valid", bus.rsp_valid, 1'b0);
      chkb("rst3_err", bus.err, 1'b0);
      chkb("rst3_req_ready", bus.req_ready, 1'b1);
      @(posedge mul_clk);
      #1;
      inj      = 1'b1;
      inj_data = 64'hDEAD_BEEF_0BAD_F00D;
      @(posedge mul_clk);
      #1;
      inj = 1'b0;
      @(negedge mul_clk);
      chkb("late_err", bus.err, 1'b1);
      chkb("late_dropped", bus.rsp_valid, 1'b0);
      @(posedge mul_clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         issue(2'b01, rnd_word(), rnd_word(), TAG_W'(i), ok);
         chkb("rst3_full_credit", ok, 1'b1);
      end
      bus.req_valid = 1'b1;
      @(negedge mul_clk);
      chkb("rst3_fifth_blocked", bus.req_ready, 1'b0);
      @(posedge mul_clk);
      #1;
      drain();
      chkb("err_sticky", bus.err, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
